// File: rtl/mac_accumulate_stage.sv
// mac_accumulate_stage: streaming multiply-accumulate back end summing product packets into a wide accumulator.
// Build option: define MAC_ACCUMULATE_STAGE_SAT_EN to clamp the sum at all ones on overflow instead of wrapping.
module mac_accumulate_stage #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);
    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
    state_t state, state_nx;
    logic [ACC_W-1:0] acc, acc_nx;
    logic [CNT_W-1:0] count, count_nx;
    logic ovf, ovf_nx;
    logic [ACC_W:0] sum;
    logic take;
    assign in_ready  = state != HOLD;
    assign out_valid = state == HOLD;
    assign take      = in_valid & in_ready;
    assign sum       = {1'b0, acc} + (ACC_W+1)'(in_product);
    assign out_acc   = acc;
    assign out_count = count;
    assign out_ovf   = ovf;
    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        count_nx = count;
        ovf_nx   = ovf;
        case (state)
            IDLE: if (take) begin
                acc_nx   = ACC_W'(in_product);
                count_nx = CNT_W'(1);
                ovf_nx   = 1'b0;
                state_nx = in_last ? HOLD : ACC;
            end
            ACC: if (take) begin
`ifdef MAC_ACCUMULATE_STAGE_SAT_EN
                // once clamped, ovf keeps the sum pinned for the rest of the packet
                acc_nx   = (sum[ACC_W] | ovf) ? '1 : sum[ACC_W-1:0];
`else
                acc_nx   = sum[ACC_W-1:0];
`endif
                count_nx = &count ? count : count + CNT_W'(1);
                ovf_nx   = ovf | sum[ACC_W];
                state_nx = in_last ? HOLD : ACC;
            end
            HOLD: if (out_ready) begin
                acc_nx   = '0;
                count_nx = '0;
                ovf_nx   = 1'b0;
                state_nx = IDLE;
            end
            default: begin
                acc_nx   = '0;
                count_nx = '0;
                ovf_nx   = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            count <= count_nx;
            ovf   <= ovf_nx;
        end
    end
endmodule

// File: tb/tb_mac_accumulate_stage.sv
// tb_mac_accumulate_stage: directed vector table plus hand-written multi-cycle sequences.
module tb_mac_accumulate_stage;
    logic        clk = 0;
    logic        rst = 1;
    logic        in_valid = 0;
    logic        in_ready;
    logic [31:0] in_product = '0;
    logic        in_last = 0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [39:0] out_acc;
    logic [7:0]  out_count;
    logic        out_ovf;
    int total = 0;
    int bad = 0;

    mac_accumulate_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_product(in_product), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] p0, p1, p2;
        int          n;
        int          gap;
        logic [39:0] acc;
        logic [7:0]  cnt;
        logic        ovf;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] p, input logic l);
        int k;
        in_valid = 1; in_product = p; in_last = l;
        k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        if (k >= 50) chk("beat_timeout", 1, 0);
        tick();
        in_valid = 0; in_last = 0;
    endtask

    task automatic idle_gap(input int g);
        for (int i = 0; i < g; i++) begin
            tick();
            chk("gap_in_ready", in_ready, 1);
            chk("gap_out_valid", out_valid, 0);
        end
    endtask

    task automatic expect_result(input string name, input logic [39:0] a, input logic [7:0] c, input logic o);
        chk({name, "_valid"}, out_valid, 1);
        chk({name, "_acc"}, out_acc, a);
        chk({name, "_count"}, out_count, c);
        chk({name, "_ovf"}, out_ovf, o);
    endtask

    initial begin
        vecs[0] = '{p0: 6, p1: 20, p2: 42, n: 3, gap: 0, acc: 40'd68, cnt: 3, ovf: 0};
        vecs[1] = '{p0: 10, p1: 20, p2: 30, n: 3, gap: 3, acc: 40'd60, cnt: 3, ovf: 0};
        vecs[2] = '{p0: 32'hFFFFFFFF, p1: 32'hFFFFFFFF, p2: 1, n: 3, gap: 0, acc: 40'h1FFFFFFFF, cnt: 3, ovf: 0};
        vecs[3] = '{p0: 0, p1: 0, p2: 0, n: 2, gap: 1, acc: 40'd0, cnt: 2, ovf: 0};
        vecs[4] = '{p0: 32'h12345678, p1: 0, p2: 0, n: 1, gap: 0, acc: 40'h0012345678, cnt: 1, ovf: 0};

        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_acc", out_acc, 0);
        chk("rst_count", out_count, 0);
        chk("rst_ovf", out_ovf, 0);
        rst = 0;
        out_ready = 1;

        foreach (vecs[v]) begin
            beat(vecs[v].p0, vecs[v].n == 1);
            if (vecs[v].n > 1) begin
                idle_gap(vecs[v].gap);
                beat(vecs[v].p1, vecs[v].n == 2);
            end
            if (vecs[v].n > 2) begin
                idle_gap(vecs[v].gap);
                beat(vecs[v].p2, 1);
            end
            expect_result($sformatf("vec%0d", v), vecs[v].acc, vecs[v].cnt, vecs[v].ovf);
            tick();
            chk("vec_drain_valid", out_valid, 0);
            chk("vec_drain_ready", in_ready, 1);
        end

        out_ready = 0;
        beat(32'hFFFE0001, 1);
        expect_result("single", 40'h00FFFE0001, 1, 0);
        in_valid = 1; in_product = 5; in_last = 1;
        chk("single_stall_ready", in_ready, 0);
        out_ready = 1;
        tick();
        out_ready = 0;
        chk("single_released_valid", out_valid, 0);
        chk("single_released_ready", in_ready, 1);
        tick();
        in_valid = 0; in_last = 0;
        expect_result("second", 40'd5, 1, 0);
        out_ready = 1;
        tick();

        out_ready = 0;
        beat(1, 0); beat(2, 0); beat(3, 1);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0]; in_product = 32'd99; in_last = 1;
            chk("bp_valid", out_valid, 1);
            chk("bp_acc", out_acc, 6);
            chk("bp_ready", in_ready, 0);
            tick();
        end
        chk("bp_count", out_count, 3);
        in_valid = 0; in_last = 0;
        out_ready = 1;
        tick();
        out_ready = 0;
        chk("bp_xfer_once", out_valid, 0);
        tick(); tick();
        chk("bp_no_repeat", out_valid, 0);
        chk("bp_cleared_acc", out_acc, 0);

        out_ready = 1;
        for (int i = 1; i <= 257; i++) beat(32'hFFFE0001, i == 257);
`ifdef MAC_ACCUMULATE_STAGE_SAT_EN
        expect_result("ovf", 40'hFFFFFFFFFF, 255, 1);
`else
        expect_result("ovf", 40'h00FDFE0101, 255, 1);
`endif
        tick();
        chk("ovf_drain", out_valid, 0);

        beat(100, 0); beat(200, 0);
        rst = 1;
        tick();
        rst = 0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_acc", out_acc, 0);
        chk("mid_rst_count", out_count, 0);
        beat(7, 1);
        expect_result("after_rst", 40'd7, 1, 0);
        tick();
        chk("after_rst_drain", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
